// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle MIPS control FSM. It sequences fetch / decode / execute /
//   memory / writeback, drives the ALU function code and the datapath
//   strobes, and stalls in the memory states for MEM_LAT cycles.
//
// Parameters
//   MEM_LAT    memory access cycles for FETCH / MEMRD / MEMWR (>= 1)
//
// Configuration macro
//   MIPS_OVF_TRAP_EN  when defined, add/sub/addi overflow diverts to a TRAP
//                     state that loads the exception vector and pulses trap.
//                     When undefined, the overflow input is ignored.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   op, funct             instruction fields from the instruction register
//   zero, overflow        ALU flags, valid in the same cycle as alu_f
//   alu_f                 ALU function code
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_src                PC next-value select
//   pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write
//                         datapath strobes
//   trap                  one-cycle overflow exception pulse
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [2:0] alu_f,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       trap
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
`ifdef MIPS_OVF_TRAP_EN
        S_TRAP    = 4'd13,
`endif
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_last;
    logic             w_ovf_trap;

    // Saturating compare: the counter never runs past CNT_LAST.
    assign w_mem_last = (r_wait_cnt >= CNT_LAST);

`ifdef MIPS_OVF_TRAP_EN
    assign w_ovf_trap = overflow;
`else
    logic w_unused_overflow;
    assign w_unused_overflow = overflow;
    assign w_ovf_trap        = 1'b0;
`endif

    // State register and memory-stall counter. The counter is cleared by
    // default every cycle and only advances while a memory state is still
    // waiting, so any state change leaves it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_START;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                S_START: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_mem_last) r_state    <= S_DECODE;
                    else            r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_RTYPEEX;
                        OP_BEQ:       r_state <= S_BEQEX;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JEX;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (w_mem_last) r_state    <= S_MEMWB;
                    else            r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                S_MEMWB: r_state <= S_FETCH;
                S_MEMWR: begin
                    if (w_mem_last) r_state    <= S_FETCH;
                    else            r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                S_RTYPEEX: begin
                    case (funct)
                        FN_ADD, FN_SUB: begin
`ifdef MIPS_OVF_TRAP_EN
                            r_state <= w_ovf_trap ? S_TRAP : S_RTYPEWB;
`else
                            r_state <= S_RTYPEWB;
`endif
                        end
                        FN_AND, FN_OR, FN_SLT: r_state <= S_RTYPEWB;
                        default:               r_state <= S_FETCH;
                    endcase
                end
                S_RTYPEWB: r_state <= S_FETCH;
                S_BEQEX:   r_state <= S_FETCH;
                S_ADDIEX: begin
`ifdef MIPS_OVF_TRAP_EN
                    r_state <= w_ovf_trap ? S_TRAP : S_ADDIWB;
`else
                    r_state <= S_ADDIWB;
`endif
                end
                S_ADDIWB: r_state <= S_FETCH;
                S_JEX:    r_state <= S_FETCH;
`ifdef MIPS_OVF_TRAP_EN
                S_TRAP:   r_state <= S_FETCH;
`endif
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the state register. BEQEX's pc_en follows zero and
    // RTYPEEX's alu_f follows funct, both sampled in the same cycle.
    always_comb begin
        alu_f      = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_f     = 3'b010;
                ir_write  = w_mem_last;
                pc_en     = w_mem_last;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_f     = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_f     = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_ADD:  alu_f = 3'b010;
                    FN_SUB:  alu_f = 3'b110;
                    FN_AND:  alu_f = 3'b000;
                    FN_OR:   alu_f = 3'b001;
                    FN_SLT:  alu_f = 3'b111;
                    default: alu_f = 3'b011;
                endcase
            end
            S_RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_f     = 3'b110;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JEX: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
`ifdef MIPS_OVF_TRAP_EN
            S_TRAP: begin
                pc_src = 2'b11;
                pc_en  = 1'b1;
                trap   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Cycle-by-cycle vector bench for mips_multicycle_ctrl with MEM_LAT = 2.
//   Each table row drives inputs on the falling edge and compares the full
//   packed output word shortly after; a hand-written sequence then exercises
//   asynchronous reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [2:0] alu_f;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, trap;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .zero(zero), .overflow(overflow),
        .alu_f(alu_f), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .trap(trap)
    );

    // Packed word: {alu_f, alu_src_a, alu_src_b, pc_src,
    //               pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, trap}
    localparam logic [15:0] E_ZERO = 16'h0000;
    localparam logic [15:0] E_F    = {3'b010, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_FL   = {3'b010, 1'b0, 2'b01, 2'b00, 8'b1001_0000};
    localparam logic [15:0] E_DEC  = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_MADR = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [15:0] E_MRD  = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0100_0000};
    localparam logic [15:0] E_MWB  = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_0110};
    localparam logic [15:0] E_MWR  = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0110_0000};
    localparam logic [15:0] E_RWB  = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1010};
    localparam logic [15:0] E_AWB  = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_0010};
    localparam logic [15:0] E_JEX  = {3'b000, 1'b0, 2'b00, 2'b10, 8'b1000_0000};
    localparam logic [15:0] E_BEQ1 = {3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000};
    localparam logic [15:0] E_BEQ0 = {3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000};
    localparam logic [15:0] E_TRAP = {3'b000, 1'b0, 2'b00, 2'b11, 8'b1000_0001};

    function automatic logic [15:0] e_rex(input logic [2:0] f);
        return {f, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        ovf;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [15:0] outs();
        return {alu_f, alu_src_a, alu_src_b, pc_src,
                pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, trap};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic v, input logic [15:0] e, input string n);
        vec_t t;
        t.rst = r; t.op = o; t.funct = f; t.zero = z; t.ovf = v; t.exp = e; t.name = n;
        vecs.push_back(t);
    endtask

    task automatic check(input logic [15:0] e, input string n);
        logic [15:0] got;
        got = outs();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", n, got, e);
        end
    endtask

    // One clock cycle: drive on the falling edge, compare 1 time unit later.
    task automatic step(input vec_t v);
        @(negedge clk);
        rst_n = v.rst; op = v.op; funct = v.funct; zero = v.zero; overflow = v.ovf;
        #1;
        check(v.exp, v.name);
    endtask

    task automatic fetch2(input string n);
        add(1, '0, '0, 0, 0, E_F,  {n, "_f0"});
        add(1, '0, '0, 0, 0, E_FL, {n, "_f1"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        add(0, '0, '0, 0, 0, E_ZERO, "reset_held");
        add(1, '0, '0, 0, 0, E_ZERO, "start");
        // lw: FETCH x2, DECODE, MEMADR, MEMRD x2, MEMWB
        fetch2("lw");
        add(1, 6'b100011, '0, 0, 0, E_DEC,  "lw_dec");
        add(1, 6'b100011, '0, 0, 0, E_MADR, "lw_madr");
        add(1, 6'b100011, '0, 0, 0, E_MRD,  "lw_rd0");
        add(1, 6'b100011, '0, 0, 0, E_MRD,  "lw_rd1");
        add(1, 6'b100011, '0, 0, 0, E_MWB,  "lw_wb");
        // sw
        fetch2("sw");
        add(1, 6'b101011, '0, 0, 0, E_DEC,  "sw_dec");
        add(1, 6'b101011, '0, 0, 0, E_MADR, "sw_madr");
        add(1, 6'b101011, '0, 0, 0, E_MWR,  "sw_wr0");
        add(1, 6'b101011, '0, 0, 0, E_MWR,  "sw_wr1");
        // slt
        fetch2("slt");
        add(1, 6'b000000, 6'b101010, 0, 0, E_DEC,           "slt_dec");
        add(1, 6'b000000, 6'b101010, 0, 0, e_rex(3'b111),   "slt_ex");
        add(1, 6'b000000, 6'b101010, 0, 0, E_RWB,           "slt_wb");
        // unsupported funct: no writeback, straight back to FETCH
        fetch2("fn0");
        add(1, 6'b000000, 6'b000000, 0, 0, E_DEC,           "fn0_dec");
        add(1, 6'b000000, 6'b000000, 0, 0, e_rex(3'b011),   "fn0_ex");
        // beq taken / not taken
        fetch2("beq1");
        add(1, 6'b000100, '0, 1, 0, E_DEC,  "beq1_dec");
        add(1, 6'b000100, '0, 1, 0, E_BEQ1, "beq1_ex");
        fetch2("beq0");
        add(1, 6'b000100, '0, 0, 0, E_DEC,  "beq0_dec");
        add(1, 6'b000100, '0, 0, 0, E_BEQ0, "beq0_ex");
        // addi with overflow
        fetch2("addi");
        add(1, 6'b001000, '0, 0, 0, E_DEC,  "addi_dec");
        add(1, 6'b001000, '0, 0, 1, E_MADR, "addi_ex");
`ifdef MIPS_OVF_TRAP_EN
        add(1, 6'b001000, '0, 0, 0, E_TRAP, "addi_trap");
`else
        add(1, 6'b001000, '0, 0, 0, E_AWB,  "addi_wb");
`endif
        // illegal opcode acts as NOP
        fetch2("nop");
        add(1, 6'b111111, '0, 0, 0, E_DEC,  "nop_dec");
        // jump
        fetch2("j");
        add(1, 6'b000010, '0, 0, 0, E_DEC,  "j_dec");
        add(1, 6'b000010, '0, 0, 0, E_JEX,  "j_ex");
        // add with overflow
        fetch2("add");
        add(1, 6'b000000, 6'b100000, 0, 0, E_DEC,         "add_dec");
        add(1, 6'b000000, 6'b100000, 0, 1, e_rex(3'b010), "add_ex");
`ifdef MIPS_OVF_TRAP_EN
        add(1, 6'b000000, 6'b100000, 0, 0, E_TRAP,        "add_trap");
`else
        add(1, 6'b000000, 6'b100000, 0, 0, E_RWB,         "add_wb");
`endif
        // and with overflow: never trapped
        fetch2("and");
        add(1, 6'b000000, 6'b100100, 0, 0, E_DEC,         "and_dec");
        add(1, 6'b000000, 6'b100100, 0, 1, e_rex(3'b000), "and_ex");
        add(1, 6'b000000, 6'b100100, 0, 1, E_RWB,         "and_wb");
        // sub / or
        fetch2("sub");
        add(1, 6'b000000, 6'b100010, 0, 0, E_DEC,         "sub_dec");
        add(1, 6'b000000, 6'b100010, 0, 0, e_rex(3'b110), "sub_ex");
        add(1, 6'b000000, 6'b100010, 0, 0, E_RWB,         "sub_wb");
        fetch2("or");
        add(1, 6'b000000, 6'b100101, 0, 0, E_DEC,         "or_dec");
        add(1, 6'b000000, 6'b100101, 0, 0, e_rex(3'b001), "or_ex");
        add(1, 6'b000000, 6'b100101, 0, 0, E_RWB,         "or_wb");
        // store leading into a mid-cycle reset
        fetch2("rst");
        add(1, 6'b101011, '0, 0, 0, E_DEC,  "rst_sw_dec");
        add(1, 6'b101011, '0, 0, 0, E_MADR, "rst_sw_madr");
        add(1, 6'b101011, '0, 0, 0, E_MWR,  "rst_sw_wr0");

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset between clock edges while in MEMWR.
        #2 rst_n = 1'b0;
        #1 check(E_ZERO, "async_rst_now");
        v.op = 6'b101011; v.funct = '0; v.zero = 0; v.ovf = 0;
        v.rst = 0; v.exp = E_ZERO; v.name = "rst_hold";   step(v);
        v.rst = 1; v.exp = E_ZERO; v.name = "rst_start";  step(v);
        v.op  = '0;
        v.rst = 1; v.exp = E_F;    v.name = "rst_f0";     step(v);
        v.rst = 1; v.exp = E_FL;   v.name = "rst_f1";     step(v);
        v.rst = 1; v.exp = E_DEC;  v.name = "rst_dec";    step(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
